// File: rtl/watch_pkg.sv
// Shared digit types, field maxima and the wrap value for the stopwatch counter.
package watch_pkg;

  localparam int unsigned BCD_W   = 4;
  localparam int unsigned FIELD_W = 2 * BCD_W;
  localparam int unsigned COUNT_W = 3 * FIELD_W;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t ONES_MAX   = 4'd9;
  localparam bcd_t HUND_MAX_T = 4'd9;
  localparam bcd_t SEC_MAX_T  = 4'd5;
  localparam bcd_t MIN_MAX_T  = 4'd5;

  localparam logic [COUNT_W-1:0] ROLL_VAL = 24'h59_59_99;

  // Wrap at or above the maximum so no out-of-range code can persist.
  function automatic bcd_t bcd_wrap_inc(input bcd_t d, input bcd_t max);
    return (d >= max) ? '0 : bcd_t'(d + BCD_W'(1));
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the stopwatch cascade: synchronous clear, increment with
// wrap at MAX, and a combinational carry into the next digit.
module bcd_digit
  import watch_pkg::*;
#(
  parameter bcd_t MAX = 4'd9
) (
  input  logic clk,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  bcd_t q_nxt;

  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = '0;
    end else if (inc) begin
      q_nxt = bcd_wrap_inc(q, MAX);
    end
  end

  // Reloads every cycle so the stored value always comes from q_nxt.
  always_ff @(posedge clk) begin
    q <= q_nxt;
  end

  assign carry = inc & (q == MAX);

endmodule

// File: rtl/watch_count.sv
// Stopwatch time base and MM:SS.hh BCD counter.
// Optional lap-hold display freeze is built when LAP_HOLD_EN is defined.
module watch_count
  import watch_pkg::*;
#(
  parameter int unsigned TICK_DIV = 100000,
  parameter int unsigned TICK_W   = 17
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               CLKEN,
  input  logic               RST,
`ifdef LAP_HOLD_EN
  input  logic               LAP,
`endif
  output logic [FIELD_W-1:0] HUND,
  output logic [FIELD_W-1:0] SEC,
  output logic [FIELD_W-1:0] MIN,
  output logic               TICK,
  output logic               ROLLOVER,
  output logic               HOLD
);

  logic              clr;
  logic              tick_c;
  logic [TICK_W-1:0] presc;
  logic [5:0]        carry;
  bcd_t              d0, d1, d2, d3, d4, d5;
  logic [COUNT_W-1:0] live;
  logic [COUNT_W-1:0] disp;

  assign clr    = RESET | RST;
  assign tick_c = CLKEN & ~clr & (presc == TICK_W'(TICK_DIV - 1));

  // Prescaler freezes (keeping the partial tick) while CLKEN is low.
  always_ff @(posedge CLK) begin
    if (clr) begin
      presc <= '0;
    end else if (CLKEN) begin
      presc <= tick_c ? '0 : presc + TICK_W'(1);
    end
  end

  bcd_digit #(.MAX(ONES_MAX))   u_hund_ones (.clk(CLK), .clr(clr), .inc(tick_c),   .q(d0), .carry(carry[0]));
  bcd_digit #(.MAX(HUND_MAX_T)) u_hund_tens (.clk(CLK), .clr(clr), .inc(carry[0]), .q(d1), .carry(carry[1]));
  bcd_digit #(.MAX(ONES_MAX))   u_sec_ones  (.clk(CLK), .clr(clr), .inc(carry[1]), .q(d2), .carry(carry[2]));
  bcd_digit #(.MAX(SEC_MAX_T))  u_sec_tens  (.clk(CLK), .clr(clr), .inc(carry[2]), .q(d3), .carry(carry[3]));
  bcd_digit #(.MAX(ONES_MAX))   u_min_ones  (.clk(CLK), .clr(clr), .inc(carry[3]), .q(d4), .carry(carry[4]));
  bcd_digit #(.MAX(MIN_MAX_T))  u_min_tens  (.clk(CLK), .clr(clr), .inc(carry[4]), .q(d5), .carry(carry[5]));

  assign live = {d5, d4, d3, d2, d1, d0};

  // A carry out of the minutes-tens digit is exactly the 59:59.99 wrap.
  always_ff @(posedge CLK) begin
    if (clr) begin
      TICK     <= 1'b0;
      ROLLOVER <= 1'b0;
    end else begin
      TICK     <= tick_c;
      ROLLOVER <= carry[5];
    end
  end

`ifdef LAP_HOLD_EN
  logic               hold;
  logic [COUNT_W-1:0] snap;

  // Snapshot the displayed live count when entering hold; count keeps running.
  always_ff @(posedge CLK) begin
    if (clr) begin
      hold <= 1'b0;
      snap <= '0;
    end else if (LAP) begin
      hold <= ~hold;
      if (!hold) begin
        snap <= live;
      end
    end
  end

  assign disp = hold ? snap : live;
  assign HOLD = hold;
`else
  assign disp = live;
  assign HOLD = 1'b0;
`endif

  assign {MIN, SEC, HUND} = disp;

endmodule
